// File: rtl/h_mux_arb_if.sv
// Bus bundle for h_mux_arb: CHANNELS upstream valid/ready channels and one
// registered valid/ready downstream port.
//   in_data   : channel i data at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel request
//   in_ready  : per-channel accept (at most one bit high)
//   out_data  : registered word
//   out_chan  : channel that supplied out_data
//   out_valid : out_data/out_chan hold an undelivered word
//   out_ready : downstream accepts the word
// slave = arbiter side, master = requester/consumer side.
interface h_mux_arb_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [CW-1:0]             out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/h_mux_arb.sv
// N-channel registered multiplexer/arbiter sharing one downstream port.
// Round-robin (RR=1) or fixed lowest-index priority (RR=0) picks one valid
// channel; the winner's word is captured into a one-entry output register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : h_mux_arb_if.slave (in_data/in_valid/in_ready, out_* handshake)
module h_mux_arb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned RR       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  h_mux_arb_if.slave  bus
);
  localparam int unsigned   CW   = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state;
  logic [CW-1:0]       ptr;
  logic [CW-1:0]       gidx;
  logic [CHANNELS-1:0] grant;
  logic                found;
  logic                can_load;
  logic                xfer;
  logic [WIDTH-1:0]    sel_data;
  logic [WIDTH-1:0]    data_q;
  logic [CW-1:0]       chan_q;
  int unsigned         idx;

  // Search starts at ptr (RR) or 0 (fixed) and wraps modulo CHANNELS;
  // the first valid channel found is the only grant bit set.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = (RR != 0) ? 32'(ptr) + k : k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && bus.in_valid[idx[CW-1:0]]) begin
        found             = 1'b1;
        grant[idx[CW-1:0]] = 1'b1;
        gidx              = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // A full register can still load when it drains in the same cycle.
  assign can_load     = (state == EMPTY) | bus.out_ready;
  assign xfer         = found & can_load;
  assign bus.in_ready = grant & {CHANNELS{can_load & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      data_q <= '0;
      chan_q <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        EMPTY: if (xfer) state <= FULL;
        FULL:  if (bus.out_ready && !xfer) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (xfer) begin
        data_q <= sel_data;
        chan_q <= gidx;
        if (RR != 0) ptr <= (gidx == LAST) ? '0 : gidx + CW'(1);
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_h_mux_arb.sv
// Bench for h_mux_arb: one round-robin and one fixed-priority instance,
// directed scenarios followed by random traffic, all checked against a
// transaction-level model of the arbiter.
module tb_h_mux_arb;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  h_mux_arb_if #(.WIDTH(16), .CHANNELS(4)) rr_if ();
  h_mux_arb_if #(.WIDTH(16), .CHANNELS(4)) fp_if ();

  h_mux_arb #(.WIDTH(16), .CHANNELS(4), .RR(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(rr_if));
  h_mux_arb #(.WIDTH(16), .CHANNELS(4), .RR(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(fp_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus currently applied, index 0 = RR instance, 1 = fixed instance
  logic [3:0]  cur_v [2];
  logic [63:0] cur_d [2];
  logic        cur_r [2];

  // model: output word register and next-preferred channel
  logic        m_valid [2];
  logic [15:0] m_data  [2];
  int          m_chan  [2];
  int          m_ptr   [2];
  int          m_win   [2];

  localparam logic [63:0] DATA_A = 64'hA003_A002_A001_A000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    rr_if.in_valid  = cur_v[0];
    rr_if.in_data   = cur_d[0];
    rr_if.out_ready = cur_r[0];
    fp_if.in_valid  = cur_v[1];
    fp_if.in_data   = cur_d[1];
    fp_if.out_ready = cur_r[1];
  endtask

  task automatic set(input int d, input logic [3:0] v, input logic [63:0] data, input logic r);
    cur_v[d] = v;
    cur_d[d] = data;
    cur_r[d] = r;
    apply();
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_chan[d]  = 0;
      m_ptr[d]   = 0;
    end
  endtask

  function automatic logic [3:0] obs_ready(input int d);
    return (d == 0) ? rr_if.in_ready : fp_if.in_ready;
  endfunction
  function automatic logic obs_valid(input int d);
    return (d == 0) ? rr_if.out_valid : fp_if.out_valid;
  endfunction
  function automatic logic [15:0] obs_data(input int d);
    return (d == 0) ? rr_if.out_data : fp_if.out_data;
  endfunction
  function automatic logic [1:0] obs_chan(input int d);
    return (d == 0) ? rr_if.out_chan : fp_if.out_chan;
  endfunction

  // Channel that would be served: first valid one counting upward from the
  // preferred channel (RR) or from channel 0 (fixed), or -1 if none / blocked.
  function automatic int winner(input int d);
    int start;
    logic [3:0] v;
    v = cur_v[d];
    if (!rst_n || (m_valid[d] && !cur_r[d])) return -1;
    start = (d == 0) ? m_ptr[d] : 0;
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // One clock: check handshake before the edge, advance the model, check outputs.
  task automatic tick();
    logic [63:0] dw;
    #1;
    for (int d = 0; d < 2; d++) begin
      m_win[d] = winner(d);
      chk($sformatf("ready%0d", d), 64'(obs_ready(d)),
          (m_win[d] >= 0) ? 64'(4'b0001 << m_win[d]) : 64'd0);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (m_win[d] >= 0) begin
        dw         = cur_d[d] >> (16 * m_win[d]);
        m_valid[d] = 1'b1;
        m_data[d]  = dw[15:0];
        m_chan[d]  = m_win[d];
        if (d == 0) m_ptr[d] = (m_win[d] + 1) % 4;
      end else if (m_valid[d] && cur_r[d]) begin
        m_valid[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("valid%0d", d), 64'(obs_valid(d)), 64'(m_valid[d]));
      chk($sformatf("data%0d", d), 64'(obs_data(d)), 64'(m_data[d]));
      chk($sformatf("chan%0d", d), 64'(obs_chan(d)), 64'(m_chan[d]));
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_model();
    rst_n = 1'b0;
    set(0, 4'b0000, 64'd0, 1'b1);
    set(1, 4'b0000, 64'd0, 1'b1);
    #3;
    chk("rst_valid", 64'(rr_if.out_valid), 64'd0);
    chk("rst_data", 64'(rr_if.out_data), 64'd0);
    chk("rst_chan", 64'(rr_if.out_chan), 64'd0);
    set(0, 4'b1111, DATA_A, 1'b1);
    set(1, 4'b1111, DATA_A, 1'b1);
    #1;
    chk("rst_ready_rr", 64'(rr_if.in_ready), 64'd0);
    chk("rst_ready_fp", 64'(fp_if.in_ready), 64'd0);
    set(0, 4'b0000, 64'd0, 1'b1);
    set(1, 4'b0000, 64'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin rotation with every channel requesting
    set(0, 4'b1111, DATA_A, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_chan", 64'(rr_if.out_chan), 64'(k % 4));
      chk("t1_data", 64'(rr_if.out_data), 64'(16'hA000 + 16'(k % 4)));
      chk("t1_onehot", 64'($countones(rr_if.in_ready)), 64'd1);
    end
    set(0, 4'b0000, 64'd0, 1'b1);
    tick();

    // fixed priority: channel 0 always wins, then channel 1 once 0 drops
    set(1, 4'b1111, DATA_A, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_data", 64'(fp_if.out_data), 64'h0000_0000_0000_A000);
    end
    set(1, 4'b1110, DATA_A, 1'b1);
    tick();
    chk("t2_chan1", 64'(fp_if.out_chan), 64'd1);
    set(1, 4'b0000, 64'd0, 1'b1);
    tick();

    // backpressure: word from ch2 held for 5 cycles, then refill without a bubble
    set(0, 4'b0100, 64'h0000_1234_0000_0000, 1'b1);
    tick();
    set(0, 4'b1111, DATA_A, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_data", 64'(rr_if.out_data), 64'h1234);
      chk("t3_hold_chan", 64'(rr_if.out_chan), 64'd2);
      chk("t3_hold_ready", 64'(rr_if.in_ready), 64'd0);
    end
    set(0, 4'b1111, DATA_A, 1'b1);
    tick();
    chk("t3_refill_valid", 64'(rr_if.out_valid), 64'd1);
    chk("t3_refill_chan", 64'(rr_if.out_chan), 64'd3);

    // pointer wrap after channel 3, then a lone channel streaming
    set(0, 4'b1000, DATA_A, 1'b1);
    tick();
    chk("t4_ch3", 64'(rr_if.out_chan), 64'd3);
    set(0, 4'b1001, DATA_A, 1'b1);
    tick();
    chk("t4_wrap_ch0", 64'(rr_if.out_chan), 64'd0);
    set(0, 4'b0010, DATA_A, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stream_ready", 64'(rr_if.in_ready), 64'b0010);
    end

    // drain to empty keeps the last word visible
    set(0, 4'b0000, DATA_A, 1'b1);
    tick();
    chk("t5_empty", 64'(rr_if.out_valid), 64'd0);
    chk("t5_keep", 64'(rr_if.out_data), 64'hA001);

    // asynchronous reset while full with ptr=2
    set(0, 4'b0010, DATA_A, 1'b1);
    tick();
    set(0, 4'b1111, DATA_A, 1'b0);
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("t6_valid", 64'(rr_if.out_valid), 64'd0);
    chk("t6_data", 64'(rr_if.out_data), 64'd0);
    chk("t6_chan", 64'(rr_if.out_chan), 64'd0);
    chk("t6_ready", 64'(rr_if.in_ready), 64'd0);
    set(0, 4'b0000, 64'd0, 1'b1);
    set(1, 4'b0000, 64'd0, 1'b1);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    set(0, 4'b1111, DATA_A, 1'b1);
    tick();
    chk("t6_first_ch0", 64'(rr_if.out_chan), 64'd0);
    chk("t6_first_data", 64'(rr_if.out_data), 64'hA000);

    // random traffic on both instances
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        set(d, 4'($urandom_range(15, 0)), {$urandom, $urandom}, ($urandom_range(3, 0) != 0));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
